// File: rtl/maxpool2d_seq.sv
// ---------------------------------------------------------------------------
// maxpool2d_seq : channel sequencer for the 2x2 max-pool/ReLU engine.
// On one accepted start it pools C channels of a WxH map held in a source
// BRAM, one channel at a time: pulses the engine start, streams one pixel per
// cycle into the engine and writes every valid pooled result to a destination
// BRAM.
//
// Ports
//   i_clk / i_rst                clock, asynchronous active-low reset
//   i_start                      start pulse (sampled only when idle)
//   i_width/i_height/i_channels  job geometry, latched at start
//   i_src_base / i_dst_base      word address of channel 0 pixel 0 / result 0
//   o_rd_en/o_rd_addr/i_rd_data  source BRAM port (read latency 1)
//   o_mp_*  / i_mp_*             pooling engine control, pixel and result
//   o_wr_en/o_wr_addr/o_wr_data  destination BRAM port (registered)
//   o_ch_idx                     channel currently being pooled
//   o_busy / o_done / o_err      job status (o_err sticky until next start)
// ---------------------------------------------------------------------------
module maxpool2d_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CH_WIDTH   = 8,
  parameter int MAX_WIDTH  = 52
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8:0]            i_width,
  input  logic [8:0]            i_height,
  input  logic [CH_WIDTH-1:0]   i_channels,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_mp_start,
  output logic [8:0]            o_mp_width,
  output logic [8:0]            o_mp_height,
  output logic [DATA_WIDTH-1:0] o_mp_data,
  input  logic [DATA_WIDTH-1:0] i_mp_data,
  input  logic                  i_mp_valid,
  input  logic                  i_mp_done,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [CH_WIDTH-1:0]   o_ch_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHK    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [8:0]            MAX_W9  = 9'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CH_WIDTH-1:0]   CH_ONE   = CH_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [8:0]            w_q, w_d, h_q, h_d;
  logic [CH_WIDTH-1:0]   c_q, c_d, ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [17:0]           pix_q, pix_d, res_q, res_d;
  logic                  err_q, err_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [17:0]           npix, nres, res_total;
  logic [CH_WIDTH-1:0]   ch_nxt;
  logic                  cfg_bad, rd_en, mp_start, done;

  assign npix      = 18'(w_q) * 18'(h_q);
  assign nres      = 18'(w_q[8:1]) * 18'(h_q[8:1]);
  // A result arriving together with done still belongs to this channel.
  assign res_total = res_q + 18'(i_mp_valid);
  assign ch_nxt    = ch_q + CH_ONE;
  assign cfg_bad   = (w_q == '0) || (h_q == '0) || (c_q == '0) ||
                     w_q[0] || h_q[0] || (w_q > MAX_W9);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    c_d      = c_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ch_d     = ch_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pix_d    = pix_q;
    res_d    = res_q;
    err_d    = err_q;
    rd_en    = 1'b0;
    mp_start = 1'b0;
    done     = 1'b0;

    // Write path runs in every state; CHK re-bases the pointer afterwards.
    if (wr_en_q) wr_ptr_d = wr_ptr_q + ADDR_ONE;
    if (i_mp_valid) res_d = res_q + 18'd1;
    if (i_mp_done && (state_q != S_STREAM) && (state_q != S_DRAIN)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          w_d     = i_width;
          h_d     = i_height;
          c_d     = i_channels;
          src_d   = i_src_base;
          dst_d   = i_dst_base;
          err_d   = 1'b0;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          rd_ptr_d = src_q;
          wr_ptr_d = dst_q;
          ch_d     = '0;
          res_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        mp_start = 1'b1;
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + ADDR_ONE;
        pix_d    = 18'd1;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        // pix_q counts reads issued; the cycle after the last read still
        // carries the final pixel, then the stream closes.
        if (pix_q != npix) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + ADDR_ONE;
          pix_d    = pix_q + 18'd1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_mp_done) begin
          if (res_total != nres) err_d = 1'b1;
          res_d = '0;
          if (ch_nxt == c_q) begin
            state_d = S_FIN;
          end else begin
            ch_d    = ch_nxt;
            state_d = S_START;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      c_q       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      ch_q      <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pix_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      c_q       <= c_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ch_q      <= ch_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pix_q     <= pix_d;
      res_q     <= res_d;
      err_q     <= err_d;
      wr_en_q   <= i_mp_valid;
      wr_data_q <= i_mp_data;
    end
  end

  assign o_rd_en     = rd_en;
  assign o_rd_addr   = rd_ptr_q;
  assign o_mp_start  = mp_start;
  assign o_mp_width  = w_q;
  assign o_mp_height = h_q;
  assign o_mp_data   = (state_q == S_STREAM) ? i_rd_data : '0;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_ptr_q;
  assign o_wr_data   = wr_data_q;
  assign o_ch_idx    = ch_q;
  assign o_busy      = (state_q != S_IDLE) && !done;
  assign o_done      = done;
  assign o_err       = err_q;

endmodule

// File: tb/tb_maxpool2d_seq.sv
// ---------------------------------------------------------------------------
// tb_maxpool2d_seq : self-checking bench for maxpool2d_seq.
// Models the source BRAM and the pooling engine, predicts every destination
// write from the source memory contents, and runs a table of jobs plus
// hand-written corner sequences (start during stream, stray done, dropped
// result, reset mid-job).
// ---------------------------------------------------------------------------
module tb_maxpool2d_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [8:0]  i_width, i_height;
  logic [7:0]  i_channels;
  logic [15:0] i_src_base, i_dst_base;
  logic        o_rd_en;
  logic [15:0] o_rd_addr;
  logic [15:0] i_rd_data;
  logic        o_mp_start;
  logic [8:0]  o_mp_width, o_mp_height;
  logic [15:0] o_mp_data;
  logic [15:0] i_mp_data;
  logic        i_mp_valid, i_mp_done;
  logic        o_wr_en;
  logic [15:0] o_wr_addr, o_wr_data;
  logic [7:0]  o_ch_idx;
  logic        o_busy, o_done, o_err;

  always #5 i_clk = ~i_clk;

  maxpool2d_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .CH_WIDTH(8), .MAX_WIDTH(52)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_width(i_width), .i_height(i_height), .i_channels(i_channels),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_mp_start(o_mp_start), .o_mp_width(o_mp_width), .o_mp_height(o_mp_height),
    .o_mp_data(o_mp_data), .i_mp_data(i_mp_data), .i_mp_valid(i_mp_valid),
    .i_mp_done(i_mp_done), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_ch_idx(o_ch_idx), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source BRAM, read latency 1.
  logic [15:0] src_mem [0:65535];
  logic [15:0] dst_mem [0:65535];
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= src_mem[o_rd_addr];

  function automatic logic signed [15:0] max4(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 0) m = 0;
    return m;
  endfunction

  // Engine model: collects W*H pixels after each start, then emits the
  // pooled results one per cycle with done on the last one.
  int          eng_phase  = 0;
  bit          eng_drop   = 1'b0;
  bit          force_done = 1'b0;
  logic [15:0] eng_pix[$];
  logic [15:0] eng_res[$];

  task automatic eng_pool();
    int w, h;
    w = int'(o_mp_width);
    h = int'(o_mp_height);
    eng_res.delete();
    for (int i = 0; i < h / 2; i++)
      for (int j = 0; j < w / 2; j++)
        eng_res.push_back(max4(eng_pix[2*i*w + 2*j],       eng_pix[2*i*w + 2*j + 1],
                               eng_pix[(2*i+1)*w + 2*j],   eng_pix[(2*i+1)*w + 2*j + 1]));
    if (eng_drop) void'(eng_res.pop_back());
  endtask

  initial begin
    i_mp_valid = 1'b0; i_mp_data = '0; i_mp_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_mp_valid = 1'b0; i_mp_data = '0; i_mp_done = force_done;
      if (i_rst !== 1'b1) begin
        eng_phase = 0;
      end else begin
        case (eng_phase)
          0: if (o_mp_start) begin eng_phase = 1; eng_pix.delete(); end
          1: begin
            eng_pix.push_back(o_mp_data);
            if (eng_pix.size() >= int'(o_mp_width) * int'(o_mp_height)) begin
              eng_pool();
              eng_phase = (eng_res.size() > 0) ? 2 : 0;
            end
          end
          default: begin
            i_mp_valid = 1'b1;
            i_mp_data  = eng_res.pop_front();
            if (eng_res.size() == 0) begin i_mp_done = 1'b1; eng_phase = 0; end
          end
        endcase
      end
    end
  end

  // Reference: expected destination writes, straight from the source memory.
  logic [15:0] exp_addr[$];
  logic [15:0] exp_data[$];

  function automatic logic signed [15:0] px(input logic [15:0] base, input int off);
    return src_mem[16'(int'(base) + off)];
  endfunction

  task automatic build_exp(input int w, h, c, input logic [15:0] src, dst, input bit drop);
    int k;
    exp_addr.delete(); exp_data.delete();
    k = 0;
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < h / 2; i++)
        for (int j = 0; j < w / 2; j++) begin
          if (!(drop && i == h/2 - 1 && j == w/2 - 1)) begin
            exp_addr.push_back(16'(int'(dst) + k));
            exp_data.push_back(max4(px(src, ch*w*h + 2*i*w + 2*j),
                                    px(src, ch*w*h + 2*i*w + 2*j + 1),
                                    px(src, ch*w*h + (2*i+1)*w + 2*j),
                                    px(src, ch*w*h + (2*i+1)*w + 2*j + 1)));
            k++;
          end
        end
  endtask

  task automatic fill(input logic [15:0] src, input int n, input int pat);
    for (int p = 0; p < n; p++)
      src_mem[16'(int'(src) + p)] = (pat == 0) ? 16'(p) :
                                    (pat == 1) ? 16'($urandom) : 16'hFF00;
  endtask

  task automatic run_job(input string tag, input int w, h, c,
                         input logic [15:0] src, dst, input bit exp_err,
                         input int exp_nw, input int poke);
    int cyc, nw, nrd, nst, done_cyc, busy_bad;
    bit cfg_bad;
    cfg_bad = (w == 0) || (h == 0) || (c == 0) || (w % 2 == 1) || (h % 2 == 1) || (w > 52);
    if (!cfg_bad) build_exp(w, h, c, src, dst, eng_drop);
    else begin exp_addr.delete(); exp_data.delete(); end
    @(negedge i_clk);
    i_width = 9'(w); i_height = 9'(h); i_channels = 8'(c);
    i_src_base = src; i_dst_base = dst; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0; nw = 0; nrd = 0; nst = 0; done_cyc = -1; busy_bad = 0;
    while (done_cyc < 0 && cyc < 20000) begin
      cyc++;
      if (o_wr_en) begin
        dst_mem[o_wr_addr] = o_wr_data;
        if (nw < exp_addr.size()) begin
          check({tag, " wr_addr"}, 32'(o_wr_addr), 32'(exp_addr[nw]));
          check({tag, " wr_data"}, 32'(o_wr_data), 32'(exp_data[nw]));
        end
        nw++;
      end
      if (o_rd_en) nrd++;
      if (o_mp_start) begin
        check({tag, " ch_idx"}, 32'(o_ch_idx), 32'(nst));
        check({tag, " mp_width"}, 32'(o_mp_width), 32'(w));
        nst++;
      end
      if (o_done) begin
        done_cyc = cyc;
        check({tag, " busy at done"}, 32'(o_busy), 32'd0);
      end else begin
        if (o_busy !== 1'b1) busy_bad++;
        i_start = (cyc == poke);
        if (cyc == poke) begin i_width = 9'd5; i_channels = 8'd7; end
        @(negedge i_clk);
      end
    end
    i_start = 1'b0;
    check({tag, " done seen"}, 32'(done_cyc > 0), 32'd1);
    check({tag, " busy during job"}, 32'(busy_bad), 32'd0);
    @(negedge i_clk);
    if (o_wr_en) nw++;
    check({tag, " err"}, 32'(o_err), 32'(exp_err));
    check({tag, " write count"}, 32'(nw), 32'(exp_nw));
    if (cfg_bad) begin
      check({tag, " done latency"}, 32'(done_cyc <= 2 && done_cyc > 0), 32'd1);
      check({tag, " no reads"}, 32'(nrd + nst), 32'd0);
    end else begin
      check({tag, " read count"}, 32'(nrd), 32'(w * h * c));
      check({tag, " start count"}, 32'(nst), 32'(c));
    end
  endtask

  typedef struct {
    int          w, h, c;
    logic [15:0] src, dst;
    int          pat;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n, c;
    bit strobe;
    i_rst = 1'b0; i_start = 1'b0; i_width = '0; i_height = '0; i_channels = '0;
    i_src_base = '0; i_dst_base = '0;

    tbl[0]  = '{4,  4, 1, 16'h0000, 16'h0100, 0, 1'b0, 4};
    tbl[1]  = '{8,  4, 3, 16'h0010, 16'h0400, 1, 1'b0, 24};
    tbl[2]  = '{4,  4, 1, 16'h0200, 16'h0300, 2, 1'b0, 4};
    tbl[3]  = '{5,  4, 1, 16'h0000, 16'h0700, 1, 1'b1, 0};
    tbl[4]  = '{54, 4, 1, 16'h0000, 16'h0700, 1, 1'b1, 0};
    tbl[5]  = '{4,  4, 0, 16'h0000, 16'h0700, 1, 1'b1, 0};
    tbl[6]  = '{0,  4, 1, 16'h0000, 16'h0700, 1, 1'b1, 0};
    tbl[7]  = '{4,  3, 1, 16'h0000, 16'h0700, 1, 1'b1, 0};
    tbl[8]  = '{52, 2, 2, 16'hFFF0, 16'hFFFA, 1, 1'b0, 52};
    tbl[9]  = '{2,  2, 4, 16'h1000, 16'h0500, 1, 1'b0, 4};
    tbl[10] = '{6,  6, 2, 16'h2000, 16'h0600, 1, 1'b0, 18};

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("reset strobes", 32'({o_rd_en, o_mp_start, o_wr_en, o_busy, o_done, o_err}), 32'd0);
    check("reset addrs", 32'({o_rd_addr, o_wr_addr}), 32'd0);
    check("reset misc", 32'({o_ch_idx, o_mp_width, o_mp_height, o_mp_data}), 32'd0);
    i_rst = 1'b1;

    for (int k = 0; k < 11; k++) begin
      if (!tbl[k].exp_err) fill(tbl[k].src, tbl[k].w * tbl[k].h * tbl[k].c, tbl[k].pat);
      run_job($sformatf("vec%0d", k), tbl[k].w, tbl[k].h, tbl[k].c, tbl[k].src,
              tbl[k].dst, tbl[k].exp_err, tbl[k].exp_nw, -1);
    end

    // Known-answer check of the ramp job.
    check("ramp r0", 32'(dst_mem[16'h0100]), 32'd5);
    check("ramp r1", 32'(dst_mem[16'h0101]), 32'd7);
    check("ramp r2", 32'(dst_mem[16'h0102]), 32'd13);
    check("ramp r3", 32'(dst_mem[16'h0103]), 32'd15);
    check("relu r0", 32'(dst_mem[16'h0300]), 32'd0);

    // Stray engine done while idle sets the error flag.
    @(negedge i_clk); force_done = 1'b1;
    @(negedge i_clk); force_done = 1'b0;
    @(negedge i_clk);
    check("stray done err", 32'(o_err), 32'd1);

    // Start pulsed mid-stream is ignored; next start also clears o_err.
    fill(16'h3000, 16, 1);
    run_job("poke", 4, 4, 1, 16'h3000, 16'h3100, 1'b0, 4, 8);

    // Engine returns one result short: error flagged, job still completes.
    fill(16'h3200, 16, 1);
    eng_drop = 1'b1;
    run_job("short", 4, 4, 1, 16'h3200, 16'h3300, 1'b1, 3, -1);
    eng_drop = 1'b0;

    // Reset in the middle of channel 1.
    fill(16'h0800, 32, 0);
    @(negedge i_clk);
    i_width = 9'd4; i_height = 9'd4; i_channels = 8'd2;
    i_src_base = 16'h0800; i_dst_base = 16'h0900; i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    n = 0; c = 0;
    while (n < 2 && c < 500) begin
      if (o_mp_start) n++;
      if (n < 2) begin @(negedge i_clk); c++; end
    end
    check("rst ch1 reached", 32'(n), 32'd2);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst mid strobes", 32'({o_rd_en, o_mp_start, o_wr_en, o_busy, o_done, o_err}), 32'd0);
    check("rst mid state", 32'({o_ch_idx, o_mp_width, o_mp_data}), 32'd0);
    strobe = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_rd_en || o_wr_en || o_mp_start) strobe = 1'b1;
    end
    check("rst held quiet", 32'(strobe), 32'd0);
    i_rst = 1'b1;
    run_job("after rst", 4, 4, 1, 16'h0800, 16'h0900, 1'b0, 4, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
